// File: rtl/addsub_seq.sv
// Sequential CHUNK-bit-per-cycle adder/subtractor with valid/ready handshake and C/V/Z/N flags.
// Optional saturation on signed overflow when ADDSUB_SAT_EN is defined.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z,
  output logic             n
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
  logic              carry_q, carry_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
  logic              rdy_q;

  logic [CHUNK:0]    sum_ext;
  logic [WIDTH-1:0]  s_shift;
  logic [WIDTH-1:0]  s_fin;
  logic              v_raw;

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
      n_q     <= n_d;
      rdy_q   <= 1'b1;
    end
  end

  // Operands shift right each RUN cycle so the active slice is always the low CHUNK bits;
  // on the last slice a_q[CHUNK-1]/b_q[CHUNK-1] are the original MSBs.
  always_comb begin
    sum_ext = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    s_shift = (s_q >> CHUNK) | (WIDTH'(sum_ext[CHUNK-1:0]) << (WIDTH - CHUNK));
    v_raw   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (s_shift[WIDTH-1] != a_q[CHUNK-1]);
`ifdef ADDSUB_SAT_EN
    s_fin   = v_raw ? (a_q[CHUNK-1] ? SMIN : SMAX) : s_shift;
`else
    s_fin   = s_shift;
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{m}};
          carry_d = m;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum_ext[CHUNK];
        s_d     = s_shift;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NCH - 1)) begin
          idx_d   = '0;
          s_d     = s_fin;
          c_d     = sum_ext[CHUNK];
          v_d     = v_raw;
          z_d     = (s_fin == '0);
          n_d     = s_fin[WIDTH-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c         = c_q;
  assign v         = v_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, which sets the operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 4, which sets the bits added per cycle; WIDTH%CHUNK==0 and CHUNK>=1; NCH = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid  input  1  operands a, b, m are presented.
REQ-006 The module SHALL have port in_ready  output  1  the block can accept operands.
REQ-007 The module SHALL have ports a, b  input  WIDTH  operands, two's complement or unsigned.
REQ-008 The module SHALL have port m  input  1  mode: 0 = a+b, 1 = a-b.
REQ-009 The module SHALL have port out_valid  output  1  the result and flags are valid.
REQ-010 The module SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-011 The module SHALL have port s  output  WIDTH  the result.
REQ-012 The module SHALL have ports c, v, z, n  output  1 each  carry-out, signed overflow, zero, negative.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-015 In IDLE, when in_valid=1, the block SHALL accept the operands on the rising clock edge:
- capture a and (b XOR {WIDTH{m}});
- set the internal carry to m and the chunk index to 0;
- go to RUN.
REQ-016 In RUN, each cycle SHALL add one CHUNK-bit slice, LSB slice first, with the carry propagated between slices; after NCH slices the FSM SHALL go to DONE.
REQ-017 out_valid SHALL be 1 exactly NCH clock edges after the accepting edge, and only in DONE.
REQ-018 In DONE, s, c, v, z and n SHALL hold stable until an edge where out_ready=1; on that edge the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-019 The block SHALL accept no new operation in the same cycle that a result is consumed; back-to-back throughput SHALL be one operation per NCH+2 cycles.
REQ-020 Changes on a, b, m and in_valid outside an IDLE accepting edge SHALL be ignored.
REQ-021 out_valid=1 with out_ready=0 SHALL stall the block indefinitely without any change to its outputs.
REQ-022 c SHALL be the carry out of bit WIDTH-1; for subtraction, c=1 means no borrow (a>=b unsigned).
REQ-023 v SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-024 z SHALL be 1 iff s==0.
REQ-025 n SHALL equal s[WIDTH-1].
REQ-026 Results SHALL be computed modulo 2^WIDTH, with no width extension.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock, force:
- the FSM to IDLE;
- the chunk index and carry to 0;
- s, c, v, z, n and out_valid to 0.
REQ-028 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 from the first cycle after release.
REQ-029 Reset asserted during RUN or DONE SHALL discard the operation in flight without producing any out_valid pulse.

Configuration
REQ-030 With ADDSUB_SAT_EN defined, when v=1 the result SHALL saturate:
- s = 0111..1 if the operand a (captured) was non-negative;
- otherwise s = 1000..0;
- z and n SHALL reflect the saturated s;
- c and v SHALL keep their raw values.
REQ-031 Without ADDSUB_SAT_EN, s SHALL wrap modulo 2^WIDTH and no saturation logic SHALL be present.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-032 a=0x7FFF, b=0x0001, m=0 -> out_valid 4 edges after accept; s=0x8000 c=0 v=1 z=0 n=1; with ADDSUB_SAT_EN, s=0x7FFF and n=0.
REQ-033 a=0x0003, b=0x0005, m=1 -> s=0xFFFE c=0 v=0 z=0 n=1.
REQ-034 a=0x1234, b=0x1234, m=1 -> s=0x0000 c=1 v=0 z=1 n=0.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, s and flags unchanged, in_ready=0 throughout; raise out_ready -> IDLE next edge, in_ready=1.
REQ-036 Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle -> out_valid, s and flags are 0 immediately, no result is emitted; after release, a=0x0001, b=0x0001, m=0 gives s=0x0002.
REQ-037 WIDTH=4, CHUNK=1: A=0111, B=1111, M=1 -> out_valid 4 edges after accept; S=1000 C=0 V=1 N=1.
